// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scanout path.
package vga_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } scan_state_t;

   localparam int DEF_H_ACTIVE    = 640;
   localparam int DEF_H_FP        = 16;
   localparam int DEF_H_SYNC      = 96;
   localparam int DEF_H_BP        = 48;
   localparam int DEF_V_ACTIVE    = 480;
   localparam int DEF_V_FP        = 10;
   localparam int DEF_V_SYNC      = 2;
   localparam int DEF_V_BP        = 33;
   localparam bit DEF_HSYNC_POL   = 1'b0;
   localparam bit DEF_VSYNC_POL   = 1'b0;
   localparam int DEF_PIXEL_WIDTH = 12;

   typedef logic [DEF_PIXEL_WIDTH-1:0] pixel_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running horizontal/vertical raster counters with sync, active and
// line/frame boundary decode.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic clk,
   input  logic reset,
   output logic active,
   output logic hsync_on,
   output logic vsync_on,
   output logic h_first,
   output logic v_first,
   output logic v_visible,
   output logic line_last,
   output logic frame_last
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] hcnt_reg;
   logic [VW-1:0] vcnt_reg;

   assign line_last  = (hcnt_reg == H_LAST);
   assign frame_last = line_last && (vcnt_reg == V_LAST);

   // Counters ignore scanout state so the monitor always sees valid timing.
   always_ff @(posedge clk) begin
      if (reset) begin
         hcnt_reg <= '0;
         vcnt_reg <= '0;
      end else if (line_last) begin
         hcnt_reg <= '0;
         vcnt_reg <= (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
      end else begin
         hcnt_reg <= hcnt_reg + 1'b1;
      end
   end

   assign v_visible = (vcnt_reg < V_ACT_C);
   assign active    = (hcnt_reg < H_ACT_C) && v_visible;
   assign hsync_on  = (hcnt_reg >= HS_START) && (hcnt_reg < HS_END);
   assign vsync_on  = (vcnt_reg >= VS_START) && (vcnt_reg < VS_END);
   assign h_first   = (hcnt_reg == '0);
   assign v_first   = (vcnt_reg == '0);

endmodule

// File: rtl/vga_scanout.sv
// Pixel-FIFO consumer: gates scanout to whole frames, pops one pixel per
// active clock, registers the video outputs and counts starved pixels.
module vga_scanout
   import vga_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter bit HSYNC_POL   = DEF_HSYNC_POL,
   parameter bit VSYNC_POL   = DEF_VSYNC_POL,
   parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   output logic                   fifo_rden,
   input  logic [PIXEL_WIDTH-1:0] fifo_rddata,
   input  logic                   fifo_rddata_valid,
   input  logic                   fifo_rddone,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   de,
   output logic [PIXEL_WIDTH-1:0] rgb,
   output logic                   frame_start,
   output logic                   line_start,
   input  logic                   underflow_clr,
   output logic [15:0]            underflow_count,
   output logic                   running
);

   localparam logic [15:0] UF_MAX = 16'hFFFF;

   logic active, hsync_on, vsync_on, h_first, v_first, v_visible;
   logic line_last, frame_last;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk        (clk),
      .reset      (reset),
      .active     (active),
      .hsync_on   (hsync_on),
      .vsync_on   (vsync_on),
      .h_first    (h_first),
      .v_first    (v_first),
      .v_visible  (v_visible),
      .line_last  (line_last),
      .frame_last (frame_last)
   );

   // Occupancy flag is advisory only; underflow is judged from fifo_rddone.
   logic unused_rddata_valid;
   assign unused_rddata_valid = fifo_rddata_valid;

   scan_state_t state_reg, state_next;

   always_ff @(posedge clk) begin
      if (reset) state_reg <= OFF;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         OFF:     if (enable) state_next = ARMED;
         ARMED: begin
            if (!enable)        state_next = OFF;
            else if (frame_last) state_next = RUN;
         end
         RUN:     if (frame_last && !enable) state_next = OFF;
         default: state_next = OFF;
      endcase
   end

   assign fifo_rden = (state_reg == RUN) && active && !reset;
   assign running   = (state_reg == RUN);

   logic                   hsync_reg, vsync_reg, de_reg;
   logic                   frame_start_reg, line_start_reg;
   logic [PIXEL_WIDTH-1:0] rgb_reg;
   logic [15:0]            underflow_count_reg;

   // All video outputs share one register stage so they stay aligned.
   always_ff @(posedge clk) begin
      if (reset) begin
         hsync_reg       <= ~HSYNC_POL;
         vsync_reg       <= ~VSYNC_POL;
         de_reg          <= 1'b0;
         rgb_reg         <= '0;
         frame_start_reg <= 1'b0;
         line_start_reg  <= 1'b0;
      end else begin
         hsync_reg       <= hsync_on ? HSYNC_POL : ~HSYNC_POL;
         vsync_reg       <= vsync_on ? VSYNC_POL : ~VSYNC_POL;
         de_reg          <= active;
         rgb_reg         <= (fifo_rden && fifo_rddone) ? fifo_rddata : '0;
         frame_start_reg <= h_first && v_first;
         line_start_reg  <= h_first && v_visible;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || underflow_clr)
         underflow_count_reg <= '0;
      else if (fifo_rden && !fifo_rddone && (underflow_count_reg != UF_MAX))
         underflow_count_reg <= underflow_count_reg + 16'd1;
   end

   assign hsync           = hsync_reg;
   assign vsync           = vsync_reg;
   assign de              = de_reg;
   assign rgb             = rgb_reg;
   assign frame_start     = frame_start_reg;
   assign line_start      = line_start_reg;
   assign underflow_count = underflow_count_reg;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a tiny 8x6 raster with a queue-based
// reference model of the frame-gated scanout behaviour.
module tb_vga_scanout;

   localparam int PW      = 12;
   localparam int H_TOT   = 8;
   localparam int V_TOT   = 6;
   localparam int F_TOT   = H_TOT * V_TOT;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          underflow_clr = 1'b0;
   logic          fifo_rden, fifo_rddone, fifo_rddata_valid;
   logic [PW-1:0] fifo_rddata;
   logic          hsync, vsync, de, frame_start, line_start, running;
   logic [PW-1:0] rgb;
   logic [15:0]   underflow_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vga_scanout #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIXEL_WIDTH(PW)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .fifo_rden(fifo_rden), .fifo_rddata(fifo_rddata),
      .fifo_rddata_valid(fifo_rddata_valid), .fifo_rddone(fifo_rddone),
      .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
      .frame_start(frame_start), .line_start(line_start),
      .underflow_clr(underflow_clr), .underflow_count(underflow_count),
      .running(running)
   );

   // Bench-side FIFO: pops whenever the DUT requests and data is present.
   logic [PW-1:0] fifo_mem [0:1023];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_rddata_valid = (wr_ptr != rd_ptr);
   assign fifo_rddata       = fifo_mem[rd_ptr % 1024];
   assign fifo_rddone       = fifo_rden && fifo_rddata_valid;
   always @(posedge clk) if (fifo_rddone) rd_ptr <= rd_ptr + 1;

   logic [PW-1:0] ref_q[$];

   task automatic push_pixel(input logic [PW-1:0] p);
      fifo_mem[wr_ptr % 1024] = p;
      wr_ptr = wr_ptr + 1;
      ref_q.push_back(p);
   endtask

   typedef struct packed {
      logic          hsync;
      logic          vsync;
      logic          de;
      logic [PW-1:0] rgb;
      logic          fs;
      logic          ls;
      logic          running;
      logic          rden;
      logic [15:0]   uc;
   } obs_t;

   obs_t exp_q[$];

   // Reference model: raster position is clock count since reset modulo the
   // frame; scanout mode is 0 idle, 1 waiting for frame start, 2 scanning.
   int m_t = 0;
   int m_mode = 0;
   int m_uc = 0;

   function automatic bit is_active(input int t);
      return ((t % H_TOT) < 4) && (((t / H_TOT) % V_TOT) < 3);
   endfunction

   always @(posedge clk) begin
      obs_t e;
      int h, v, nxt;
      bit act, starved;
      e = '0;
      if (reset) begin
         m_t = 0; m_mode = 0; m_uc = 0;
         e.hsync = 1'b1; e.vsync = 1'b1;
      end else begin
         h = m_t % H_TOT;
         v = (m_t / H_TOT) % V_TOT;
         act = is_active(m_t);
         starved = 1'b0;
         if (m_mode == 2 && act) begin
            if (ref_q.size() > 0) e.rgb = ref_q.pop_front();
            else starved = 1'b1;
            $display("xfer t=%0t h=%0d v=%0d pixel=%h starved=%0b", $time, h, v, e.rgb, starved);
         end
         if (underflow_clr)               m_uc = 0;
         else if (starved && m_uc < 65535) m_uc = m_uc + 1;
         e.hsync = !(h == 5 || h == 6);
         e.vsync = (v != 4);
         e.de    = act;
         e.fs    = (h == 0 && v == 0);
         e.ls    = (h == 0 && v < 3);
         nxt = m_mode;
         if (m_mode == 0 && enable) nxt = 1;
         else if (m_mode == 1) nxt = !enable ? 0 : ((m_t == F_TOT - 1) ? 2 : 1);
         else if (m_mode == 2 && m_t == F_TOT - 1 && !enable) nxt = 0;
         m_mode = nxt;
         m_t = (m_t + 1) % F_TOT;
         e.running = (m_mode == 2);
         e.rden    = (m_mode == 2) && is_active(m_t);
      end
      e.uc = m_uc[15:0];
      exp_q.push_back(e);
   end

   // Monitor: the DUT presents a full output set every clock.
   always @(posedge clk) begin
      obs_t e, g;
      #1;
      g = '{hsync, vsync, de, rgb, frame_start, line_start, running, fifo_rden, underflow_count};
      checks = checks + 1;
      if (exp_q.size() == 0) begin
         failures = failures + 1;
         $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
         e = exp_q.pop_front();
         if (g !== e) begin
            failures = failures + 1;
            $display("FAIL video_out t=%0t got hs=%b vs=%b de=%b rgb=%h fs=%b ls=%b run=%b rden=%b uc=%h required hs=%b vs=%b de=%b rgb=%h fs=%b ls=%b run=%b rden=%b uc=%h",
                     $time, g.hsync, g.vsync, g.de, g.rgb, g.fs, g.ls, g.running, g.rden, g.uc,
                     e.hsync, e.vsync, e.de, e.rgb, e.fs, e.ls, e.running, e.rden, e.uc);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_running(input logic level, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3 * F_TOT; i++) begin
         if (running === level) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      checks = checks + 1;
      if (!seen) begin
         failures = failures + 1;
         $display("FAIL %s got running=%b required %b within %0d clocks", name, running, level, 3 * F_TOT);
      end
   endtask

   initial begin
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(2 * F_TOT);

      // Full frame of known pixels, then enable dropped mid-frame.
      for (int i = 1; i <= 12; i++) push_pixel(PW'(i));
      tick(20);
      enable = 1'b1;
      wait_running(1'b1, "run_after_enable");
      tick(20);
      enable = 1'b0;
      wait_running(1'b0, "stop_after_disable");
      tick(F_TOT);

      // Short FIFO: 7 starved pixels, hold, then clear.
      for (int i = 0; i < 5; i++) push_pixel(PW'(12'h0A0 + i));
      enable = 1'b1;
      wait_running(1'b1, "run_short_fifo");
      tick(10);
      enable = 1'b0;
      wait_running(1'b0, "stop_short_fifo");
      tick(20);
      underflow_clr = 1'b1;
      tick(1);
      underflow_clr = 1'b0;
      tick(10);

      // Randomised enable, clear and FIFO fill traffic.
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 39) == 0) enable = ~enable;
         underflow_clr = ($urandom_range(0, 49) == 0);
         if ((wr_ptr - rd_ptr) < 16 && $urandom_range(0, 2) == 0)
            push_pixel(PW'($urandom));
         tick(1);
      end
      underflow_clr = 1'b0;

      // Reset pulse at hcnt=2, vcnt=1 during RUN.
      enable = 1'b1;
      for (int i = 0; i < 12; i++) push_pixel(PW'($urandom));
      wait_running(1'b1, "run_before_reset");
      for (int i = 0; i < 2 * F_TOT && m_t != 10; i++) tick(1);
      checks = checks + 1;
      if (m_t != 10) begin
         failures = failures + 1;
         $display("FAIL reset_position got t=%0d required 10", m_t);
      end
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      enable = 1'b0;
      tick(2 * F_TOT);

      // Saturation: preset close to the top, then starve for several frames.
      dut.underflow_count_reg = 16'hFFF0;
      m_uc = 65520;
      enable = 1'b1;
      tick(5 * F_TOT);
      enable = 1'b0;
      tick(F_TOT + 4);
      checks = checks + 1;
      if (underflow_count !== 16'hFFFF) begin
         failures = failures + 1;
         $display("FAIL underflow_saturate got %h required ffff", underflow_count);
      end

      tick(3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
